// File: rtl/trig_pkg.sv
// Shared definitions for the Sdtrig-style trigger unit: CSR addresses, tdata1 layout,
// match types and the packed view of a channel's writable configuration.
package trig_pkg;

    localparam logic [11:0] CSR_TSELECT = 12'h7A0;
    localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
    localparam logic [11:0] CSR_TDATA2  = 12'h7A2;
    localparam logic [11:0] CSR_TINFO   = 12'h7A4;

    localparam logic [3:0]  TYPE_MCONTROL = 4'd2;
    localparam logic [31:0] TINFO_VALUE   = 32'h0000_0004;

    localparam int TD1_DMODE    = 27;
    localparam int TD1_HIT      = 20;
    localparam int TD1_ACTION   = 12;
    localparam int TD1_MATCH_HI = 10;
    localparam int TD1_MATCH_LO = 7;
    localparam int TD1_M        = 6;
    localparam int TD1_EXECUTE  = 2;
    localparam int TD1_STORE    = 1;
    localparam int TD1_LOAD     = 0;

    typedef enum logic [3:0] {
        MATCH_EQ = 4'd0,
        MATCH_GE = 4'd2,
        MATCH_LT = 4'd3
    } match_e;

    typedef enum logic {
        ST_ARMED,
        ST_SUPPRESS
    } supp_state_e;

    typedef struct packed {
        logic   dmode;
        logic   hit;
        logic   action;
        match_e match;
        logic   m;
        logic   execute;
        logic   store;
        logic   load;
    } tdata1_t;

    function automatic match_e legalMatch(input logic [3:0] raw);
        case (raw)
            4'd2:    return MATCH_GE;
            4'd3:    return MATCH_LT;
            default: return MATCH_EQ;
        endcase
    endfunction

    // Unimplemented tdata1 bits read as zero; type is hardwired.
    function automatic logic [31:0] packTdata1(input tdata1_t c);
        return {TYPE_MCONTROL, c.dmode, 6'b0, c.hit, 7'b0, c.action, 1'b0,
                c.match, c.m, 3'b0, c.execute, c.store, c.load};
    endfunction

endpackage

// File: rtl/rv_trigger_unit_if.sv
// Core-side CSR access and match/trigger signals of the trigger unit.
interface rv_trigger_unit_if #(
    parameter int Width = 32
);
    logic [11:0]      csr_addr;
    logic             csr_write;
    logic [Width-1:0] csr_wdata;
    logic [Width-1:0] csr_rdata;
    logic             csr_hit;
    logic             halted;
    logic             resuming;
    logic             retire;
    logic [Width-1:0] pc;
    logic             pc_valid;
    logic [Width-1:0] mem_addr;
    logic             mem_rd;
    logic             mem_wr;
    logic             breakp;
    logic             dbg_req;
    logic [3:0]       hit_idx;

    modport master (
        output csr_addr, csr_write, csr_wdata, halted, resuming, retire,
               pc, pc_valid, mem_addr, mem_rd, mem_wr,
        input  csr_rdata, csr_hit, breakp, dbg_req, hit_idx
    );

    modport slave (
        input  csr_addr, csr_write, csr_wdata, halted, resuming, retire,
               pc, pc_valid, mem_addr, mem_rd, mem_wr,
        output csr_rdata, csr_hit, breakp, dbg_req, hit_idx
    );
endinterface

// File: rtl/rv_trigger_channel.sv
// One mcontrol trigger: tdata1/tdata2 storage, sticky hit, address comparator and fire.
module rv_trigger_channel
    import trig_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrTdata1_i,
    input  logic             wrTdata2_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             halted_i,
    input  logic             suppress_i,
    input  logic [Width-1:0] pc_i,
    input  logic             pcValid_i,
    input  logic [Width-1:0] memAddr_i,
    input  logic             memRd_i,
    input  logic             memWr_i,
    output logic [31:0]      tdata1_o,
    output logic [Width-1:0] tdata2_o,
    output logic             fire_o,
    output logic             action_o
);

    tdata1_t          cfg_q, cfg_d;
    logic [Width-1:0] tdata2_q, tdata2_d;
    logic             writeOk;
    logic             newDmode;
    logic             execMatch;
    logic             memMatch;

    function automatic logic cmpAddr(input logic [Width-1:0] a,
                                     input logic [Width-1:0] ref_val,
                                     input match_e mt);
        case (mt)
            MATCH_EQ: return a == ref_val;
            MATCH_GE: return a >= ref_val;
            MATCH_LT: return a < ref_val;
            default:  return 1'b0;
        endcase
    endfunction

    // A debug-owned trigger is locked against M-mode software.
    assign writeOk  = ~cfg_q.dmode | halted_i;
    assign newDmode = halted_i & wdata_i[TD1_DMODE];

    assign execMatch = cfg_q.execute & pcValid_i & ~suppress_i
                     & cmpAddr(pc_i, tdata2_q, cfg_q.match);
    assign memMatch  = ((cfg_q.load & memRd_i) | (cfg_q.store & memWr_i))
                     & cmpAddr(memAddr_i, tdata2_q, cfg_q.match);

    assign fire_o   = cfg_q.m & (execMatch | memMatch) & ~halted_i;
    assign action_o = cfg_q.action;
    assign tdata1_o = packTdata1(cfg_q);
    assign tdata2_o = tdata2_q;

    always_comb begin
        cfg_d    = cfg_q;
        tdata2_d = tdata2_q;
        if (fire_o) begin
            cfg_d.hit = 1'b1;
        end
        // An accepted CSR write overrides the hit set from the same cycle.
        if (wrTdata1_i && writeOk) begin
            cfg_d.dmode   = newDmode;
            cfg_d.hit     = wdata_i[TD1_HIT];
            cfg_d.action  = wdata_i[TD1_ACTION] & newDmode;
            cfg_d.match   = legalMatch(wdata_i[TD1_MATCH_HI:TD1_MATCH_LO]);
            cfg_d.m       = wdata_i[TD1_M];
            cfg_d.execute = wdata_i[TD1_EXECUTE];
            cfg_d.store   = wdata_i[TD1_STORE];
            cfg_d.load    = wdata_i[TD1_LOAD];
        end
        if (wrTdata2_i && writeOk) begin
            tdata2_d = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q    <= '0;
            tdata2_q <= '0;
        end else begin
            cfg_q    <= cfg_d;
            tdata2_q <= tdata2_d;
        end
    end

endmodule

// File: rtl/rv_trigger_unit.sv
// Trigger unit top: tselect, post-resume suppress FSM, channel array, hit priority and CSR read mux.
module rv_trigger_unit
    import trig_pkg::*;
#(
    parameter int NumTriggers = 4,
    parameter int Width       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    rv_trigger_unit_if.slave bus
);

    logic [3:0]       tselect_q, tselect_d;
    supp_state_e      state_q, state_d;
    logic             suppress;
    logic             wrTsel, wrTdata1, wrTdata2;
    logic             anyDbg, anyExc;
    logic [31:0]      selTdata1;
    logic [Width-1:0] selTdata2;

    logic [NumTriggers-1:0] fire;
    logic [NumTriggers-1:0] action;
    logic [31:0]            tdata1Arr [NumTriggers];
    logic [Width-1:0]       tdata2Arr [NumTriggers];

    assign wrTsel   = bus.csr_write && (bus.csr_addr == CSR_TSELECT);
    assign wrTdata1 = bus.csr_write && (bus.csr_addr == CSR_TDATA1);
    assign wrTdata2 = bus.csr_write && (bus.csr_addr == CSR_TDATA2);
    assign suppress = (state_q == ST_SUPPRESS);

    for (genvar g = 0; g < NumTriggers; g++) begin : gChannel
        rv_trigger_channel #(.Width(Width)) uChannel (
            .clk        (clk),
            .rst_n      (rst_n),
            .wrTdata1_i (wrTdata1 && (tselect_q == 4'(g))),
            .wrTdata2_i (wrTdata2 && (tselect_q == 4'(g))),
            .wdata_i    (bus.csr_wdata),
            .halted_i   (bus.halted),
            .suppress_i (suppress),
            .pc_i       (bus.pc),
            .pcValid_i  (bus.pc_valid),
            .memAddr_i  (bus.mem_addr),
            .memRd_i    (bus.mem_rd),
            .memWr_i    (bus.mem_wr),
            .tdata1_o   (tdata1Arr[g]),
            .tdata2_o   (tdata2Arr[g]),
            .fire_o     (fire[g]),
            .action_o   (action[g])
        );
    end

    // Resuming outranks retire so a resume on a retiring cycle still masks the next instruction.
    always_comb begin
        state_d   = state_q;
        tselect_d = tselect_q;
        case (state_q)
            ST_ARMED:    if (bus.resuming) state_d = ST_SUPPRESS;
            ST_SUPPRESS: if (!bus.resuming && bus.retire) state_d = ST_ARMED;
            default:     state_d = ST_ARMED;
        endcase
        if (wrTsel && (bus.csr_wdata < Width'(NumTriggers))) begin
            tselect_d = bus.csr_wdata[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARMED;
            tselect_q <= '0;
        end else begin
            state_q   <= state_d;
            tselect_q <= tselect_d;
        end
    end

    always_comb begin
        anyDbg      = |(fire & action);
        anyExc      = |(fire & ~action);
        bus.dbg_req = anyDbg;
        bus.breakp  = anyExc & ~anyDbg;
        bus.hit_idx = '0;
        for (int i = NumTriggers - 1; i >= 0; i--) begin
            if (fire[i]) bus.hit_idx = 4'(i);
        end
    end

    always_comb begin
        selTdata1 = '0;
        selTdata2 = '0;
        for (int i = 0; i < NumTriggers; i++) begin
            if (tselect_q == 4'(i)) begin
                selTdata1 = tdata1Arr[i];
                selTdata2 = tdata2Arr[i];
            end
        end
        bus.csr_hit   = 1'b0;
        bus.csr_rdata = '0;
        case (bus.csr_addr)
            CSR_TSELECT: begin bus.csr_hit = 1'b1; bus.csr_rdata = Width'(tselect_q);   end
            CSR_TDATA1:  begin bus.csr_hit = 1'b1; bus.csr_rdata = Width'(selTdata1);   end
            CSR_TDATA2:  begin bus.csr_hit = 1'b1; bus.csr_rdata = selTdata2;           end
            CSR_TINFO:   begin bus.csr_hit = 1'b1; bus.csr_rdata = Width'(TINFO_VALUE); end
            default:     ;
        endcase
    end

endmodule
